// File: rtl/controller_data_ram_arbiter.sv
// Two-master round-robin arbiter with lock in front of a single-port data RAM.
// Optional macro CONTROLLER_DATA_RAM_ARB_FIXED_PRIO_EN: m0 always wins a tie.
module controller_data_ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_lock,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  input  logic [DATA_W-1:0]     ram_readdata
);

  logic       r_lock_valid;
  logic       r_lock_owner;
  logic [1:0] r_rd_pend;

  logic [1:0] w_rd;
  logic [1:0] w_wr;
  logic [1:0] w_req;
  logic [1:0] w_lock_in;
  logic [1:0] w_eligible;
  logic [1:0] w_gnt;
  logic       w_any_gnt;
  logic       w_gnt_idx;
  logic       w_lock_hold;

  assign w_rd      = {m1_read, m0_read};
  assign w_wr      = {m1_write, m0_write};
  assign w_req     = w_rd | w_wr;
  assign w_lock_in = {m1_lock, m0_lock};

  // A lock whose owner has already dropped mX_lock no longer blocks this cycle.
  assign w_lock_hold = r_lock_valid & w_lock_in[r_lock_owner];

`ifndef CONTROLLER_DATA_RAM_ARB_FIXED_PRIO_EN
  logic r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_any_gnt) begin
      r_last <= w_gnt_idx;
    end
  end
`endif

  always_comb begin
    w_eligible = w_req;
    if (w_lock_hold) begin
      w_eligible = w_req & (r_lock_owner ? 2'b10 : 2'b01);
    end
    w_gnt = 2'b00;
    case (w_eligible)
      2'b01: w_gnt = 2'b01;
      2'b10: w_gnt = 2'b10;
`ifdef CONTROLLER_DATA_RAM_ARB_FIXED_PRIO_EN
      2'b11: w_gnt = 2'b01;
`else
      2'b11: w_gnt = r_last ? 2'b01 : 2'b10;
`endif
      default: w_gnt = 2'b00;
    endcase
    if (reset) begin
      w_gnt = 2'b00;
    end
  end

  assign w_any_gnt = |w_gnt;
  assign w_gnt_idx = w_gnt[1];

  assign m0_waitrequest = ~w_gnt[0];
  assign m1_waitrequest = ~w_gnt[1];

  assign ram_chipselect = w_any_gnt;
  assign ram_write      = w_any_gnt & w_wr[w_gnt_idx];
  assign ram_address    = w_gnt_idx ? m1_address    : m0_address;
  assign ram_byteenable = w_gnt_idx ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = w_gnt_idx ? m1_writedata  : m0_writedata;

  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = r_rd_pend[0];
  assign m1_readdatavalid = r_rd_pend[1];

  // Read+write together is a write, so only pure reads return data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend <= 2'b00;
    end else begin
      r_rd_pend <= w_gnt & w_rd & ~w_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (w_any_gnt && w_lock_in[w_gnt_idx]) begin
      r_lock_valid <= 1'b1;
      r_lock_owner <= w_gnt_idx;
    end else if (r_lock_valid && !w_lock_in[r_lock_owner]) begin
      r_lock_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_data_ram_arbiter.sv
// Bench for controller_data_ram_arbiter: vector table, hand sequences, random vs model.
module tb_controller_data_ram_arbiter;

`ifdef CONTROLLER_DATA_RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_readdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  controller_data_ram_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_readdata(ram_readdata)
  );

  // Power-up contents of the RAM, shared by the RAM stand-in and the model.
  function automatic logic [31:0] init_word(input logic [10:0] a);
    if (a == 11'h005) return 32'hDEADBEEF;
    if (a == 11'h7FF) return 32'hAABBCCDD;
    return 32'h5A5A0000 | {21'h0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // RAM stand-in: single port, registered q, byte-masked writes.
  logic [31:0] tb_mem [0:2047];
  bit          written [0:2047];

  function automatic logic [31:0] cur_word(input logic [10:0] a);
    return written[a] ? tb_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        tb_mem[ram_address]  <= merge(cur_word(ram_address), ram_writedata, ram_byteenable);
        written[ram_address] <= 1'b1;
      end
      ram_readdata <= cur_word(ram_address);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] c0, input logic [10:0] a0, input logic [3:0] be0,
                        input logic [31:0] wd0, input logic [2:0] c1, input logic [10:0] a1,
                        input logic [3:0] be1, input logic [31:0] wd1);
    {m0_lock, m0_write, m0_read} = c0;
    m0_address = a0; m0_byteenable = be0; m0_writedata = wd0;
    {m1_lock, m1_write, m1_read} = c1;
    m1_address = a1; m1_byteenable = be1; m1_writedata = wd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control field encoding is {lock, write, read}.
  typedef struct {
    logic [2:0]  c0; logic [10:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic [2:0]  c1; logic [10:0] a1; logic [3:0] be1; logic [31:0] wd1;
    int          exp_gnt;
    int          exp_rdv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  // Reference model state for the random phase.
  int          m_last, m_lockv, m_owner, m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [0:2047];

  initial begin
    vec_t v;
    int g;
    logic [1:0]  rrd, rwr, rlk;
    logic [10:0] ra [2];
    logic [3:0]  rbe [2];
    logic [31:0] rwd [2];
    bit cand [2];

    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i[10:0]);

    vecs[0]  = '{3'b001, 11'h005, 4'hF, 32'h0, 3'b001, 11'h7FF, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF};
    vecs[1]  = '{3'b001, 11'h005, 4'hF, 32'h0, 3'b001, 11'h7FF, 4'hF, 32'h0, FIXED ? 0 : 1,
                 FIXED ? 0 : 1, FIXED ? 32'hDEADBEEF : 32'hAABBCCDD};
    vecs[2]  = '{3'b001, 11'h005, 4'hF, 32'h0, 3'b001, 11'h7FF, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF};
    vecs[3]  = vecs[1];
    vecs[4]  = '{3'b001, 11'h005, 4'hF, 32'h0, 3'b000, 11'h000, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF};
    vecs[5]  = '{3'b000, 11'h000, 4'h0, 32'h0, 3'b000, 11'h000, 4'h0, 32'h0, -1, -1, 32'h0};
    vecs[6]  = '{3'b000, 11'h000, 4'h0, 32'h0, 3'b010, 11'h7FF, 4'b0011, 32'h11223344, 1, -1, 32'h0};
    vecs[7]  = '{3'b000, 11'h000, 4'h0, 32'h0, 3'b001, 11'h7FF, 4'hF, 32'h0, 1, 1, 32'hAABB3344};
    vecs[8]  = '{3'b011, 11'h001, 4'hF, 32'hCAFE0001, 3'b011, 11'h002, 4'hF, 32'hBEEF0002, 0, -1, 32'h0};
    vecs[9]  = '{3'b011, 11'h001, 4'hF, 32'hCAFE0001, 3'b011, 11'h002, 4'hF, 32'hBEEF0002,
                 FIXED ? 0 : 1, -1, 32'h0};
    vecs[10] = '{3'b001, 11'h001, 4'hF, 32'h0, 3'b000, 11'h000, 4'h0, 32'h0, 0, 0, 32'hCAFE0001};
    vecs[11] = '{3'b000, 11'h000, 4'h0, 32'h0, 3'b001, 11'h002, 4'hF, 32'h0, 1, 1,
                 FIXED ? 32'h5A5A0002 : 32'hBEEF0002};

    // Reset state, with m0 already requesting.
    reset = 1'b1;
    set_in(3'b001, 11'h005, 4'hF, 32'h0, 3'b000, 11'h0, 4'h0, 32'h0);
    tick(); tick();
    chk("rst_w0", m0_waitrequest, 1'b1);
    chk("rst_w1", m1_waitrequest, 1'b1);
    chk("rst_cs", ram_chipselect, 1'b0);
    chk("rst_we", ram_write, 1'b0);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      set_in(v.c0, v.a0, v.be0, v.wd0, v.c1, v.a1, v.be1, v.wd1);
      #1;
      chk($sformatf("row%0d_w0", i), m0_waitrequest, v.exp_gnt != 0);
      chk($sformatf("row%0d_w1", i), m1_waitrequest, v.exp_gnt != 1);
      chk($sformatf("row%0d_cs", i), ram_chipselect, v.exp_gnt >= 0);
      if (v.exp_gnt == 0) begin
        chk($sformatf("row%0d_we", i), ram_write, v.c0[1]);
        chk($sformatf("row%0d_addr", i), ram_address, v.a0);
        if (v.c0[1]) chk($sformatf("row%0d_wd", i), ram_writedata, v.wd0);
      end else if (v.exp_gnt == 1) begin
        chk($sformatf("row%0d_we", i), ram_write, v.c1[1]);
        chk($sformatf("row%0d_addr", i), ram_address, v.a1);
        if (v.c1[1]) begin
          chk($sformatf("row%0d_wd", i), ram_writedata, v.wd1);
          chk($sformatf("row%0d_be", i), ram_byteenable, v.be1);
        end
      end else begin
        chk($sformatf("row%0d_we", i), ram_write, 1'b0);
      end
      tick();
      chk($sformatf("row%0d_rdv0", i), m0_readdatavalid, v.exp_rdv == 0);
      chk($sformatf("row%0d_rdv1", i), m1_readdatavalid, v.exp_rdv == 1);
      if (v.exp_rdv == 0) chk($sformatf("row%0d_rd0", i), m0_readdata, v.exp_data);
      if (v.exp_rdv == 1) chk($sformatf("row%0d_rd1", i), m1_readdata, v.exp_data);
    end

    // Lock: m0 holds the RAM across idle cycles; m1 requests throughout.
    set_in(3'b101, 11'h010, 4'hF, 32'h0, 3'b001, 11'h020, 4'hF, 32'h0);
    #1;
    chk("lk_rd_w0", m0_waitrequest, 1'b0);
    chk("lk_rd_w1", m1_waitrequest, 1'b1);
    tick();
    chk("lk_rd_rdv0", m0_readdatavalid, 1'b1);
    chk("lk_rd_data", m0_readdata, 32'h5A5A0010);
    for (int k = 0; k < 2; k++) begin
      set_in(3'b100, 11'h010, 4'hF, 32'h0, 3'b001, 11'h020, 4'hF, 32'h0);
      #1;
      chk($sformatf("lk_idle%0d_w1", k), m1_waitrequest, 1'b1);
      chk($sformatf("lk_idle%0d_cs", k), ram_chipselect, 1'b0);
      tick();
    end
    set_in(3'b110, 11'h010, 4'hF, 32'h01020304, 3'b001, 11'h020, 4'hF, 32'h0);
    #1;
    chk("lk_wr_w0", m0_waitrequest, 1'b0);
    chk("lk_wr_w1", m1_waitrequest, 1'b1);
    chk("lk_wr_we", ram_write, 1'b1);
    tick();
    set_in(3'b000, 11'h010, 4'hF, 32'h0, 3'b001, 11'h020, 4'hF, 32'h0);
    #1;
    chk("lk_rel_w1", m1_waitrequest, 1'b0);
    chk("lk_rel_addr", ram_address, 11'h020);
    tick();
    chk("lk_rel_rdv1", m1_readdatavalid, 1'b1);
    chk("lk_rel_data", m1_readdata, 32'h5A5A0020);

    // Reset right after a locked read: return dropped, lock released.
    set_in(3'b101, 11'h005, 4'hF, 32'h0, 3'b000, 11'h0, 4'h0, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("rs1_rdv0", m0_readdatavalid, 1'b0);
    chk("rs1_w0", m0_waitrequest, 1'b1);
    chk("rs1_cs", ram_chipselect, 1'b0);
    tick();
    chk("rs1_rdv0b", m0_readdatavalid, 1'b0);
    reset = 1'b0;
    set_in(3'b100, 11'h005, 4'hF, 32'h0, 3'b001, 11'h020, 4'hF, 32'h0);
    #1;
    chk("rs1_unlock_w1", m1_waitrequest, 1'b0);
    tick();

    // Reset after an m0 grant: the next tie still goes to m0.
    set_in(3'b001, 11'h005, 4'hF, 32'h0, 3'b000, 11'h0, 4'h0, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("rs2_rdv0", m0_readdatavalid, 1'b0);
    tick();
    reset = 1'b0;
    set_in(3'b001, 11'h005, 4'hF, 32'h0, 3'b001, 11'h006, 4'hF, 32'h0);
    #1;
    chk("rs2_tie_w0", m0_waitrequest, 1'b0);
    chk("rs2_tie_w1", m1_waitrequest, 1'b1);
    tick();
    chk("rs2_rdv0", m0_readdatavalid, 1'b1);

    // Random traffic against the model, starting from a fresh reset.
    set_in(3'b000, 11'h0, 4'h0, 32'h0, 3'b000, 11'h0, 4'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_last = 1; m_lockv = 0; m_owner = 0; m_pend = -1; m_pend_data = '0;
    for (int n = 0; n < 1500; n++) begin
      chk("rnd_rdv0", m0_readdatavalid, m_pend == 0);
      chk("rnd_rdv1", m1_readdatavalid, m_pend == 1);
      if (m_pend == 0) chk("rnd_rd0", m0_readdata, m_pend_data);
      if (m_pend == 1) chk("rnd_rd1", m1_readdata, m_pend_data);

      for (int i = 0; i < 2; i++) begin
        rrd[i] = 1'($urandom % 2);
        rwr[i] = ($urandom % 4) == 0;
        rlk[i] = ($urandom % 4) == 0;
        ra[i]  = 11'h100 + 11'($urandom % 16);
        rbe[i] = 4'($urandom % 16);
        rwd[i] = $urandom;
      end
      set_in({rlk[0], rwr[0], rrd[0]}, ra[0], rbe[0], rwd[0],
             {rlk[1], rwr[1], rrd[1]}, ra[1], rbe[1], rwd[1]);

      // Who may be served: requesters, minus anyone shut out by a held lock.
      for (int i = 0; i < 2; i++) begin
        cand[i] = rrd[i] | rwr[i];
        if (m_lockv != 0 && rlk[m_owner] && i != m_owner) cand[i] = 1'b0;
      end
      if (!cand[0] && !cand[1]) g = -1;
      else if (cand[0] && !cand[1]) g = 0;
      else if (!cand[0] && cand[1]) g = 1;
      else g = FIXED ? 0 : 1 - m_last;

      #1;
      chk("rnd_w0", m0_waitrequest, g != 0);
      chk("rnd_w1", m1_waitrequest, g != 1);
      chk("rnd_cs", ram_chipselect, g >= 0);
      chk("rnd_we", ram_write, (g >= 0) && rwr[g]);
      if (g >= 0) begin
        chk("rnd_addr", ram_address, ra[g]);
        if (rwr[g]) begin
          chk("rnd_be", ram_byteenable, rbe[g]);
          chk("rnd_wd", ram_writedata, rwd[g]);
        end
      end

      m_pend = -1;
      if (g >= 0) begin
        m_last = g;
        if (rwr[g]) ref_mem[ra[g]] = merge(ref_mem[ra[g]], rwd[g], rbe[g]);
        else begin
          m_pend = g;
          m_pend_data = ref_mem[ra[g]];
        end
      end
      if (g >= 0 && rlk[g]) begin
        m_lockv = 1;
        m_owner = g;
      end else if (m_lockv != 0 && !rlk[m_owner]) begin
        m_lockv = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_data_ram_arbiter.md
# controller_data_ram_arbiter

Two-port round-robin arbiter placed in front of the controller's 2048×32 single-port data RAM. It lets two Avalon-MM requesters share the RAM: one transfer per cycle, waitrequest back-pressure to the losing requester, and read data routed back with readdatavalid one cycle after grant. It also supports a lock, so one requester can hold the RAM for an atomic read-modify-write sequence.

## Interface
- `ADDR_W`, 11, word address width (2048 words)
- `DATA_W`, 32, data width; byteenable width is DATA_W/8
- `clk` in 1, sole clock
- `reset` in 1, asynchronous, active-high
- `m0_address`, `m1_address` in ADDR_W, word address
- `m0_byteenable`, `m1_byteenable` in 4, byte lanes for write
- `m0_read`, `m1_read` in 1, read request
- `m0_write`, `m1_write` in 1, write request
- `m0_writedata`, `m1_writedata` in DATA_W, write data
- `m0_lock`, `m1_lock` in 1, request to hold ownership after the current granted transfer
- `m0_waitrequest`, `m1_waitrequest` out 1, high = request not accepted this cycle
- `m0_readdata`, `m1_readdata` out DATA_W, read data
- `m0_readdatavalid`, `m1_readdatavalid` out 1, one-cycle read return strobe
- `ram_address` out ADDR_W; `ram_byteenable` out 4; `ram_writedata` out DATA_W
- `ram_chipselect` out 1; `ram_write` out 1
- `ram_readdata` in DATA_W, RAM q (valid 1 cycle after address)

## Operation
- Request: `mX_req = mX_read | mX_write`. If both read and write are asserted, the transfer is a write; the read is ignored and no readdatavalid is returned.
- Grant is combinational each cycle. A granted master sees waitrequest=0. A requesting master that is not granted sees waitrequest=1. A non-requesting master also sees waitrequest=1.
- Round-robin:
  - Register `last` (0/1) records the master granted most recently.
  - When both request, the master ≠ `last` wins. When one requests, it wins.
  - `last` updates only on a granted cycle.
- Lock:
  - Register `lock_valid` and `lock_owner`.
  - Set on a granted transfer with `mX_lock`=1.
  - Cleared in any cycle where the owner's `mX_lock`=0.
  - While `lock_valid`, only the owner can be granted. The other master waits even if the owner is idle.
  - A clear and a new request take effect in the same cycle: a master with lock low is arbitrated normally.
- RAM drive:
  - On grant, `ram_chipselect`=1 and the granted master's address, byteenable and writedata are muxed out.
  - `ram_write`=1 for write transfers only.
  - With no grant, `ram_chipselect`=0 and `ram_write`=0.
- Read return:
  - Register `rd_pend[1:0]` is set for the granted read master and cleared otherwise.
  - `mX_readdatavalid` = `rd_pend[X]`. Both `m0_readdata` and `m1_readdata` = `ram_readdata`.
- Write byte masking is done by the RAM. The arbiter passes byteenable unmodified; byteenable is ignored on reads.

## Timing
- Reset state:
  - `last`=1, so m0 wins the first tie.
  - `lock_valid`=0, `rd_pend`=0.
  - All readdatavalid outputs 0; `ram_chipselect`/`ram_write` 0.
  - Both waitrequest outputs 1 while `reset` is asserted.
- Grant latency is 0: a request is accepted in the same cycle if it wins.
- Read latency: accepted in cycle N → readdatavalid and data in cycle N+1.
- Throughput: one transfer per cycle, back-to-back. Reads and writes interleave freely with no turnaround.
- Reset mid-read: a pending readdatavalid is dropped. The lock is released.
- A master must hold its request stable while waitrequest=1 (Avalon rule). The arbiter does not latch requests.

## Configuration
- `CONTROLLER_DATA_RAM_ARB_FIXED_PRIO_EN`:
  - Defined: m0 always wins a tie and `last` is unused. The lock still overrides priority.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then m0 reads addr 0x005 (RAM word 0xDEADBEEF) with m1 idle → m0_waitrequest=0 in cycle 0; m0_readdatavalid=1 and m0_readdata=0xDEADBEEF in cycle 1; m1_readdatavalid=0.
- Both masters assert read continuously for 4 cycles → grants alternate m0,m1,m0,m1; each readdatavalid lands 1 cycle after its grant.
- m1 writes 0x11223344 with byteenable 0b0011 to 0x7FF, then reads 0x7FF → ram_write=1 only on the write cycle; readback shows low 16 bits 0x3344 and upper bytes unchanged.
- m0 reads 0x010 with m0_lock=1, idles 2 cycles, writes 0x010, then drops lock; m1 requests throughout → m1_waitrequest=1 until the cycle m0_lock=0, then m1 is granted.
- Both masters assert read+write together, addresses 0x001/0x002 → writes performed; no readdatavalid generated.
- Assert reset the cycle after a granted read → readdatavalid stays 0, lock cleared, and the next tie goes to m0.
